// File: rtl/cpu_fpu_div_issue.sv
// Requester side of the FPU divider request/ready handshake: queues divide ops,
// issues them one at a time, and returns tagged results in push order.
module cpu_fpu_div_issue #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [31:0]          i_op1,
  input  logic [31:0]          i_op2,
  input  logic [TAG_WIDTH-1:0] i_tag,
  output logic                 o_full,
  input  logic                 i_flush,
  output logic                 o_div_request,
  output logic [31:0]          o_div_op1,
  output logic [31:0]          o_div_op2,
  input  logic                 i_div_ready,
  input  logic [31:0]          i_div_result,
  output logic                 o_valid,
  output logic [31:0]          o_result,
  output logic [TAG_WIDTH-1:0] o_tag,
  input  logic                 i_result_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t               r_state, w_state_next;
  logic [31:0]          r_q_op1 [DEPTH];
  logic [31:0]          r_q_op2 [DEPTH];
  logic [TAG_WIDTH-1:0] r_q_tag [DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_req, r_discard, r_valid;
  logic [31:0]          r_op1, r_op2, r_result;
  logic [TAG_WIDTH-1:0] r_tag, r_otag;
  logic                 w_push, w_issue, w_capture, w_empty;

  assign o_full        = (r_count == CW'(DEPTH));
  assign w_empty       = (r_count == '0);
  assign w_push        = i_valid && !o_full && !i_flush;
  assign o_div_request = r_req;
  assign o_div_op1     = r_op1;
  assign o_div_op2     = r_op2;
  assign o_valid       = r_valid;
  assign o_result      = r_result;
  assign o_tag         = r_otag;

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !i_flush) begin
          w_issue      = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        // Hold the request while the result slot is occupied; the divider keeps its result stable.
        if (i_div_ready && (!r_valid || i_result_ready)) begin
          w_capture    = 1'b1;
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!i_div_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_DRAIN;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_q_op1[r_wr_ptr] <= i_op1;
      r_q_op2[r_wr_ptr] <= i_op2;
      r_q_tag[r_wr_ptr] <= i_tag;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_issue)      r_count <= r_count + CW'(1);
      else if (!w_push && w_issue) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_DRAIN;
      r_req     <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_tag     <= '0;
      r_discard <= 1'b0;
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_otag    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) begin
        r_req     <= 1'b1;
        r_op1     <= r_q_op1[r_rd_ptr];
        r_op2     <= r_q_op2[r_rd_ptr];
        r_tag     <= r_q_tag[r_rd_ptr];
        r_discard <= 1'b0;
      end else if (r_state == S_REQ && i_flush) begin
        r_discard <= 1'b1;
      end
      // A flush landing on the capture edge also cancels the in-flight result.
      if (w_capture) begin
        r_req    <= 1'b0;
        r_result <= i_div_result;
        r_otag   <= r_tag;
        r_valid  <= !(r_discard || i_flush);
      end else if (r_valid && i_result_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_fpu_div_issue.sv
// Scoreboard bench for cpu_fpu_div_issue with a four-phase divider responder model.
module tb_cpu_fpu_div_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_op1 = '0;
  logic [31:0] i_op2 = '0;
  logic [4:0]  i_tag = '0;
  logic        o_full;
  logic        i_flush = 1'b0;
  logic        o_div_request;
  logic [31:0] o_div_op1, o_div_op2;
  logic        div_ready = 1'b0;
  logic [31:0] div_result = '0;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_tag;
  logic        i_result_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] sb[$];

  logic [31:0] v_op1 [8] = '{32'h3f800000, 32'h40c00000, 32'h3f800000, 32'h41200000,
                             32'h41000000, 32'h40400000, 32'h42c80000, 32'h40800000};
  logic [31:0] v_op2 [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40a00000,
                             32'h40000000, 32'h3f800000, 32'h41200000, 32'h40000000};
  logic [31:0] v_quo [8] = '{32'h3f000000, 32'h40000000, 32'h3e800000, 32'h40000000,
                             32'h40800000, 32'h40400000, 32'h41200000, 32'h40000000};

  cpu_fpu_div_issue #(.DEPTH(2), .TAG_WIDTH(5)) dut (
    .i_clock(clk), .i_reset(rst), .i_valid(i_valid), .i_op1(i_op1), .i_op2(i_op2),
    .i_tag(i_tag), .o_full(o_full), .i_flush(i_flush), .o_div_request(o_div_request),
    .o_div_op1(o_div_op1), .o_div_op2(o_div_op2), .i_div_ready(div_ready),
    .i_div_result(div_result), .o_valid(o_valid), .o_result(o_result), .o_tag(o_tag),
    .i_result_ready(i_result_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  function automatic logic [31:0] div_lookup(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 8; i++)
      if (v_op1[i] == a && v_op2[i] == b) return v_quo[i];
    return 32'hdeadbeef;
  endfunction

  // Divider responder: ready after dm_lat cycles, held until request drops, released after dm_drop_lat.
  typedef enum {DM_IDLE, DM_BUSY, DM_DONE, DM_DROP} dm_t;
  dm_t         dm_state = DM_IDLE;
  int          dm_cnt = 0;
  int          dm_lat = 5;
  int          dm_drop_lat = 2;
  logic [31:0] dm_op1, dm_op2;

  always @(negedge clk) begin
    case (dm_state)
      DM_IDLE: if (o_div_request) begin
        dm_op1 = o_div_op1;
        dm_op2 = o_div_op2;
        dm_cnt = dm_lat;
        dm_state = DM_BUSY;
      end
      DM_BUSY: begin
        check("req_held", 64'(o_div_request), 64'd1);
        check("ops_stable", {o_div_op1, o_div_op2}, {dm_op1, dm_op2});
        if (dm_cnt <= 1) begin
          div_ready = 1'b1;
          div_result = div_lookup(dm_op1, dm_op2);
          dm_state = DM_DONE;
        end else dm_cnt--;
      end
      DM_DONE: begin
        if (!o_div_request) begin
          dm_cnt = dm_drop_lat;
          dm_state = DM_DROP;
        end else check("ops_stable_rdy", {o_div_op1, o_div_op2}, {dm_op1, dm_op2});
      end
      DM_DROP: begin
        check("no_req_while_ready", 64'(o_div_request), 64'd0);
        if (dm_cnt <= 1) begin
          div_ready = 1'b0;
          dm_state = DM_IDLE;
        end else dm_cnt--;
      end
    endcase
  end

  always @(negedge clk) begin
    if (!rst && o_valid && i_result_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %h tag %0d expected none", o_result, o_tag);
      end else begin
        check("result", {o_result, o_tag}, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [4:0] tag, input bit exp);
    i_valid = 1'b1;
    i_op1 = v_op1[idx];
    i_op2 = v_op2[idx];
    i_tag = tag;
    if (exp) sb.push_back({v_quo[idx], tag});
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int k;
    for (k = 0; k < 1000; k++) begin
      if (sb.size() == 0 && dm_state == DM_IDLE && !div_ready && !o_div_request) break;
      tick();
    end
    if (k == 1000) timeout_fail(name);
    repeat (3) tick();
  endtask

  initial begin
    int k;
    logic bad;
    #2 rst = 1'b1;
    #1;
    check("reset_outputs", {o_full, o_div_request, o_div_op1, o_div_op2, o_valid, o_result, o_tag}, '0);
    tick();
    rst = 1'b0;
    tick();

    // 1) single op, request one cycle after the push edge
    push(0, 5'd3, 1'b1);
    check("t1_req_not_yet", 64'(o_div_request), 64'd0);
    tick();
    check("t1_req_rise", 64'(o_div_request), 64'd1);
    check("t1_ops", {o_div_op1, o_div_op2}, {v_op1[0], v_op2[0]});
    wait_drained("t1_drain");

    // 2) back-to-back pushes
    push(1, 5'd1, 1'b1);
    push(2, 5'd2, 1'b1);
    wait_drained("t2_drain");

    // 3) fill the queue, then a dropped push while full
    push(3, 5'd4, 1'b1);
    check("t3_full_after1", 64'(o_full), 64'd0);
    push(4, 5'd5, 1'b1);
    check("t3_req_after2", 64'(o_div_request), 64'd1);
    check("t3_full_after2", 64'(o_full), 64'd0);
    push(5, 5'd6, 1'b1);
    check("t3_full_after3", 64'(o_full), 64'd1);
    push(6, 5'd31, 1'b0);
    check("t3_still_full", 64'(o_full), 64'd1);
    wait_drained("t3_drain");

    // 4) result slot held; second op must wait in REQ with request high
    i_result_ready = 1'b0;
    push(3, 5'd7, 1'b1);
    push(4, 5'd8, 1'b1);
    for (k = 0; k < 500; k++) begin
      if (dm_state == DM_DONE && o_div_request && o_valid) break;
      tick();
    end
    if (k == 500) timeout_fail("t4_stall");
    repeat (3) tick();
    check("t4_req_held", 64'(o_div_request), 64'd1);
    check("t4_first_held", {o_valid, o_result, o_tag}, {1'b1, v_quo[3], 5'd7});
    i_result_ready = 1'b1;
    wait_drained("t4_drain");

    // 5) flush in REQ with one op queued
    push(3, 5'd11, 1'b0);
    push(4, 5'd12, 1'b0);
    check("t5_req", 64'(o_div_request), 64'd1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("t5_not_full", 64'(o_full), 64'd0);
    for (k = 0; k < 200; k++) begin
      if (!o_div_request) break;
      tick();
    end
    if (k == 200) timeout_fail("t5_req_drop");
    bad = 1'b0;
    repeat (30) begin
      tick();
      if (o_div_request || o_valid) bad = 1'b1;
    end
    check("t5_nothing_issued", 64'(bad), 64'd0);
    wait_drained("t5_drain");

    // 6) reset while divider ready is high
    dm_drop_lat = 8;
    push(7, 5'd9, 1'b0);
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (div_ready) break;
    end
    if (k == 200) timeout_fail("t6_ready");
    rst = 1'b1;
    #1;
    check("t6_reset_outputs", {o_div_request, o_valid, o_full}, '0);
    tick();
    rst = 1'b0;
    push(0, 5'd10, 1'b1);
    tick();
    check("t6_ready_still_high", 64'(div_ready), 64'd1);
    check("t6_no_req_while_ready", 64'(o_div_request), 64'd0);
    dm_drop_lat = 2;
    wait_drained("t6_drain");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
